// File: rtl/sm_alu_seq.sv
// Sign-magnitude add/sub/mul/div unit with start/done handshake; mul and div iterate one bit per cycle.
// Define SM_ALU_REMAINDER_EN to return the divide remainder in resultado[2W-1:W].
module sm_alu_seq #(
   parameter int W = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   num1,
   input  logic           sig1,
   input  logic [W-1:0]   num2,
   input  logic           sig2,
   input  logic [1:0]     oper,
   output logic           busy,
   output logic           done,
   output logic           error,
   output logic [2*W-1:0] resultado,
   output logic           signo_resultado
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t           state;
   logic [W-1:0]     a_mag, b_mag;
   logic             a_sig, b_sig, res_sig;
   logic [1:0]       op;
   logic [CW-1:0]    cnt;
   logic [2*W-1:0]   acc, mcand;
   logic [W-1:0]     mplier, rem, quo;

   logic             b_eff_sig, add_sig;
   logic [W:0]       add_mag;
   logic [W:0]       shifted;
   logic             div_ge;
   logic [W-1:0]     div_diff;
   logic [2*W-1:0]   fin_mag;
   logic             fin_sig, fin_err;
   logic [W-1:0]     rem_field;

   // Signed add; subtraction just flips the sign of B before the same path
   always_comb begin
      b_eff_sig = (op == 2'd1) ? ~b_sig : b_sig;
      if (a_sig == b_eff_sig) begin
         add_mag = {1'b0, a_mag} + {1'b0, b_mag};
         add_sig = a_sig;
      end else if (a_mag >= b_mag) begin
         add_mag = {1'b0, a_mag} - {1'b0, b_mag};
         add_sig = a_sig;
      end else begin
         add_mag = {1'b0, b_mag} - {1'b0, a_mag};
         add_sig = b_eff_sig;
      end
   end

   // One restoring-division step; the partial remainder is always below b_mag, so W-bit wraparound subtraction is exact
   always_comb begin
      shifted  = {rem, quo[W-1]};
      div_ge   = (shifted >= {1'b0, b_mag});
      div_diff = shifted[W-1:0] - b_mag;
   end

`ifdef SM_ALU_REMAINDER_EN
   assign rem_field = rem;
`else
   assign rem_field = '0;
`endif

   always_comb begin
      fin_mag = acc;
      fin_sig = res_sig;
      fin_err = 1'b0;
      case (op)
         2'd2: fin_sig = a_sig ^ b_sig;
         2'd3: begin
            if (b_mag == '0) begin
               fin_mag = '0;
               fin_err = 1'b1;
               fin_sig = 1'b0;
            end else begin
               fin_mag = {rem_field, quo};
               fin_sig = (quo != '0) && (a_sig ^ b_sig);
            end
         end
         default: ;
      endcase
      if (op != 2'd3 && fin_mag == '0)
         fin_sig = 1'b0;
   end

   // Control FSM plus the iterative datapath; cnt==0 in CALC is the setup cycle for mul/div
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         resultado       <= '0;
         signo_resultado <= 1'b0;
         a_mag           <= '0;
         b_mag           <= '0;
         a_sig           <= 1'b0;
         b_sig           <= 1'b0;
         res_sig         <= 1'b0;
         op              <= '0;
         cnt             <= '0;
         acc             <= '0;
         mcand           <= '0;
         mplier          <= '0;
         rem             <= '0;
         quo             <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_mag <= num1;
                  a_sig <= sig1;
                  b_mag <= num2;
                  b_sig <= sig2;
                  op    <= oper;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               if (!op[1]) begin
                  acc     <= {{(W-1){1'b0}}, add_mag};
                  res_sig <= add_sig;
                  state   <= FIN;
               end else if (op == 2'd3 && b_mag == '0) begin
                  state <= FIN;
               end else if (cnt == '0) begin
                  acc    <= '0;
                  mcand  <= {{W{1'b0}}, a_mag};
                  mplier <= b_mag;
                  rem    <= '0;
                  quo    <= a_mag;
                  cnt    <= CW'(1);
               end else begin
                  if (op == 2'd2) begin
                     if (mplier[0])
                        acc <= acc + mcand;
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                  end else begin
                     rem <= div_ge ? div_diff : shifted[W-1:0];
                     quo <= {quo[W-2:0], div_ge};
                  end
                  if (cnt == CW'(W))
                     state <= FIN;
                  else
                     cnt <= cnt + CW'(1);
               end
            end
            FIN: begin
               resultado       <= fin_mag;
               signo_resultado <= fin_sig;
               error           <= fin_err;
               done            <= 1'b1;
               busy            <= 1'b0;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sm_alu_seq.sv
// Self-checking bench for sm_alu_seq: directed plan cases plus random vectors against a signed-integer reference model.
module tb_sm_alu_seq;

   localparam int W = 10;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   num1, num2;
   logic           sig1, sig2;
   logic [1:0]     oper;
   logic           busy, done, error, signo_resultado;
   logic [2*W-1:0] resultado;

   int vectors     = 0;
   int miscompares = 0;

   sm_alu_seq #(.W(W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .num1(num1), .sig1(sig1), .num2(num2), .sig2(sig2), .oper(oper),
      .busy(busy), .done(done), .error(error),
      .resultado(resultado), .signo_resultado(signo_resultado)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference: operands as signed integers, result from ordinary arithmetic
   function automatic void refModel(input logic [W-1:0] a, input logic sa, input logic [W-1:0] b,
                                    input logic sb, input logic [1:0] op,
                                    output longint mag, output bit sg, output bit err, output int lat);
      longint va, vb, r, q, rm;
      va  = sa ? -longint'(a) : longint'(a);
      vb  = sb ? -longint'(b) : longint'(b);
      err = 1'b0;
      lat = (op >= 2) ? W + 2 : 2;
      r   = 0;
      case (op)
         2'd0: r = va + vb;
         2'd1: r = va - vb;
         2'd2: r = va * vb;
         default: ;
      endcase
      if (op != 2'd3) begin
         mag = (r < 0) ? -r : r;
         sg  = (r < 0);
      end else if (b == '0) begin
         mag = 0;
         sg  = 1'b0;
         err = 1'b1;
         lat = 2;
      end else begin
         q   = longint'(a) / longint'(b);
         rm  = longint'(a) % longint'(b);
         mag = q;
`ifdef SM_ALU_REMAINDER_EN
         mag = q + (rm << W);
`endif
         sg  = (q != 0) && (sa ^ sb);
      end
   endfunction

   task automatic scrambleInputs();
      num1 = W'($urandom);
      num2 = W'($urandom);
      sig1 = 1'($urandom);
      sig2 = 1'($urandom);
      oper = 2'($urandom);
   endtask

   task automatic applyStimulus(input logic [W-1:0] a, input logic sa, input logic [W-1:0] b,
                                input logic sb, input logic [1:0] op, input bit poke);
      longint exp_mag;
      bit     exp_sg, exp_err;
      int     exp_lat, lat, busy_drops, extra;
      refModel(a, sa, b, sb, op, exp_mag, exp_sg, exp_err, exp_lat);
      @(negedge clk);
      num1 = a; sig1 = sa; num2 = b; sig2 = sb; oper = op;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_start", 64'(busy), 64'd1);
      scrambleInputs();
      lat = 0;
      busy_drops = 0;
      while (!done && lat < 100) begin
         start = (poke && lat == 3);
         if (poke && lat == 3)
            scrambleInputs();
         @(negedge clk);
         lat++;
         if (!done && !busy)
            busy_drops++;
      end
      start = 1'b0;
      checkOutput("latency", 64'(lat), 64'(exp_lat));
      checkOutput("busy_gap", 64'(busy_drops), 64'd0);
      checkOutput("busy_at_done", 64'(busy), 64'd0);
      checkOutput("resultado", 64'(resultado), 64'(exp_mag));
      checkOutput("signo", 64'(signo_resultado), 64'(exp_sg));
      checkOutput("error", 64'(error), 64'(exp_err));
      @(negedge clk);
      checkOutput("done_width", 64'(done), 64'd0);
      checkOutput("hold", 64'(resultado), 64'(exp_mag));
      if (poke) begin
         extra = 0;
         repeat (W + 4) begin
            @(negedge clk);
            if (done) extra++;
         end
         checkOutput("poke_extra_done", 64'(extra), 64'd0);
         checkOutput("poke_result", 64'(resultado), 64'(exp_mag));
      end
   endtask

   function automatic logic [W-1:0] pickMag();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return W'(1);
         2: return '1;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int dones;
      rst = 1'b1; start = 1'b0;
      num1 = '0; num2 = '0; sig1 = 1'b0; sig2 = 1'b0; oper = '0;
      #12;
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_error", 64'(error), 64'd0);
      checkOutput("reset_resultado", 64'(resultado), 64'd0);
      checkOutput("reset_signo", 64'(signo_resultado), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(10'd5,    1'b1, 10'd3,    1'b0, 2'd0, 1'b0);
      applyStimulus(10'd3,    1'b1, 10'd3,    1'b1, 2'd1, 1'b0);
      applyStimulus(10'd7,    1'b0, 10'd4,    1'b1, 2'd1, 1'b0);
      applyStimulus(10'd1023, 1'b1, 10'd1023, 1'b0, 2'd2, 1'b1);
      applyStimulus(10'd0,    1'b0, 10'd5,    1'b1, 2'd2, 1'b0);
      applyStimulus(10'd1000, 1'b1, 10'd7,    1'b0, 2'd3, 1'b0);
      applyStimulus(10'd1000, 1'b0, 10'd0,    1'b0, 2'd3, 1'b0);
      applyStimulus(10'd9,    1'b0, 10'd2,    1'b0, 2'd3, 1'b0);

      for (int i = 0; i < 40; i++)
         applyStimulus(pickMag(), 1'($urandom), pickMag(), 1'($urandom), 2'($urandom), 1'b0);

      // Abort a multiply with reset after a nonzero, negative result is on the outputs
      applyStimulus(10'd5, 1'b1, 10'd3, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      num1 = 10'd1023; sig1 = 1'b1; num2 = 10'd1023; sig2 = 1'b0; oper = 2'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_done", 64'(done), 64'd0);
      checkOutput("abort_error", 64'(error), 64'd0);
      checkOutput("abort_resultado", 64'(resultado), 64'd0);
      checkOutput("abort_signo", 64'(signo_resultado), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (W + 6) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      checkOutput("abort_no_done", 64'(dones), 64'd0);

      applyStimulus(10'd12, 1'b0, 10'd5, 1'b1, 2'd2, 1'b0);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
